display_scan_ctrl: RTL and testbench
====================================

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 1000, meaning clock cycles each digit is driven per scan slot (>=2).
REQ-002 SHALL have parameter GUARD, default 2, meaning clock cycles of all-anodes-off between digits (>=1).
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port enable  input  1  1 = scan display, 0 = display off.
REQ-006 SHALL have port load  input  1  single-cycle strobe, capture data.
REQ-007 SHALL have port data  input  16  four BCD digits, data[3:0] = digit 0 (rightmost).
REQ-008 SHALL have port lz_blank  input  1  1 = blank leading zeros on digits 3..1.
REQ-009 SHALL have port an  output  4  digit anodes, active-low, at most one low.
REQ-010 SHALL have port abcdefg  output  7  segments, active-high, bit 6 = a.
REQ-011 SHALL have port pending  output  1  captured data not yet displayed.
REQ-012 SHALL have port load_ack  output  1  one-cycle pulse when pending data becomes displayed.
REQ-013 SHALL have port frame_tick  output  1  one-cycle pulse at end of each digit-3 guard.

Function
REQ-014 SHALL hold a shadow register (captured data) and a display register (shown data), both 16 bits.
REQ-015 SHALL, on load=1, copy data into shadow and set pending=1 next cycle; a load while pending overwrites shadow.
REQ-016 SHALL commit shadow to display, clear pending and pulse load_ack only at a frame boundary (frame_tick cycle) or while in OFF.
REQ-017 SHALL, when load coincides with a commit, commit the old shadow, store the new data and leave pending=1.
REQ-018 SHALL implement states OFF, DRIVE, GUARD and a 2-bit digit index.
REQ-019 SHALL transition OFF->DRIVE (index 0) the cycle after enable is sampled 1.
REQ-020 SHALL stay in DRIVE exactly DIV cycles, then GUARD exactly GUARD cycles, then DRIVE with index+1 mod 4.
REQ-021 SHALL assert frame_tick in the last GUARD cycle of index 3.
REQ-022 SHALL, when enable is sampled 0 in any state, enter OFF next cycle, reset index to 0; a partial frame produces no frame_tick.
REQ-023 SHALL register an and abcdefg; in DRIVE index k: an = ~(1<<k), abcdefg = decode of display digit k.
REQ-024 SHALL drive an=4'b1111 and abcdefg=7'b0000000 in OFF and GUARD.
REQ-025 SHALL decode 0-9 to standard segment patterns (0=7'b1111110, 1=7'b0110000, 8=7'b1111111); codes 10-15 SHALL give 7'b0000000 with anode still driven.
REQ-026 SHALL, with lz_blank=1, blank digit k (k=3..1) when it and all higher digits are 0: an stays 4'b1111 for that slot; digit 0 is never blanked.
REQ-027 SHALL size counters as $clog2 of DIV and GUARD; no counter wrap other than index mod 4.

Reset
REQ-028 SHALL on rst_n=0 immediately force: state OFF, index 0, shadow=display=16'h0000, pending=0, load_ack=0, frame_tick=0, an=4'b1111, abcdefg=7'b0000000.
REQ-029 SHALL resume per REQ-019 after rst_n release; reset mid-frame discards pending data.

Structure
REQ-030 SHALL place state encoding, segment pattern constants and the blank pattern in a shared package.
REQ-031 SHALL instantiate the team's BCD-to-7-segment decoder Encoder (BCD in, abcdefg out) as the single sub-module, gating codes >9 in the controller.

Verification (DIV=4, GUARD=1, frame = 20 cycles)
REQ-032 SHALL cover: reset, enable=1, load data=16'h1234 -> commits immediately via OFF, load_ack once; an cycles 1110,1101,1011,0111, digit 0 segments 7'b0110011 ("4").
REQ-033 SHALL cover: load 16'h5678 mid-frame -> pending=1 until frame_tick, display changes only at next digit-0 slot.
REQ-034 SHALL cover: load coincident with frame_tick -> old shadow shown, pending stays 1, new data shown one frame later.
REQ-035 SHALL cover: lz_blank=1, data=16'h0007 -> an only 1110, segments 7'b1110000; data 16'h00A0 -> digit 1 slot driven, segments 0.
REQ-036 SHALL cover: enable dropped mid-DRIVE index 2 -> an=1111 next cycle, no frame_tick; re-enable restarts at index 0.
REQ-037 SHALL cover: rst_n asserted asynchronously mid-DRIVE -> an=1111, abcdefg=0, pending=0 without waiting for clk.

Source files
------------

// File: rtl/display_scan_ctrl_pkg.sv
// Shared definitions for the multiplexed 4-digit seven-segment scan controller:
// scan states, segment patterns and the all-off (blank) patterns.
package display_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GUARD = 2'd2
    } state_e;

    localparam logic [3:0] AN_OFF    = 4'b1111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [3:0] BCD_MAX   = 4'd9;

    // Segment order is {a,b,c,d,e,f,g}, active-high.
    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1111011;

    function automatic logic [3:0] an_select(input logic [1:0] idx);
        an_select = ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Host-side bundle of the scan controller: control/data inputs and the display
// plus status outputs.
interface display_scan_ctrl_if;
    logic        enable;
    logic        load;
    logic [15:0] data;
    logic        lz_blank;
    logic [3:0]  an;
    logic [6:0]  abcdefg;
    logic        pending;
    logic        load_ack;
    logic        frame_tick;

    modport master (
        output enable, load, data, lz_blank,
        input  an, abcdefg, pending, load_ack, frame_tick
    );

    modport slave (
        input  enable, load, data, lz_blank,
        output an, abcdefg, pending, load_ack, frame_tick
    );
endinterface

// File: rtl/display_scan_ctrl_encoder.sv
// BCD to seven-segment decoder; non-decimal codes decode to all segments off.
module display_scan_ctrl_encoder
    import display_scan_ctrl_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] abcdefg_o
);

    // Segment lookup
    always_comb begin
        abcdefg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    abcdefg_o = SEG_0;
            4'd1:    abcdefg_o = SEG_1;
            4'd2:    abcdefg_o = SEG_2;
            4'd3:    abcdefg_o = SEG_3;
            4'd4:    abcdefg_o = SEG_4;
            4'd5:    abcdefg_o = SEG_5;
            4'd6:    abcdefg_o = SEG_6;
            4'd7:    abcdefg_o = SEG_7;
            4'd8:    abcdefg_o = SEG_8;
            4'd9:    abcdefg_o = SEG_9;
            default: abcdefg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed display scanner with double-buffered data: new values
// are captured in a shadow register and only shown from the next frame boundary.
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int DIV   = 1000,
    parameter int GUARD = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    display_scan_ctrl_if.slave bus
);

    localparam int DW = $clog2(DIV);
    localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;
    localparam logic [DW-1:0] DIV_LAST   = DW'(DIV - 1);
    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD - 1);

    state_e        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [GW-1:0] gcnt_q, gcnt_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [15:0]   disp_q, disp_d;
    logic          pending_q, pending_d;
    logic          ack_q, ack_d;
    logic          tick_q, tick_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;

    logic          commit_s;
    logic          blank_s;
    logic [3:0]    cur_digit_s;
    logic [6:0]    enc_seg_s;

    // Scan sequencing: OFF -> DRIVE(DIV) -> GUARD(GUARD) -> next digit
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dcnt_d  = dcnt_q;
        gcnt_d  = gcnt_q;
        if (!bus.enable) begin
            state_d = ST_OFF;
            idx_d   = 2'd0;
            dcnt_d  = '0;
            gcnt_d  = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_DRIVE;
                    idx_d   = 2'd0;
                    dcnt_d  = '0;
                end
                ST_DRIVE: begin
                    if (dcnt_q == DIV_LAST) begin
                        state_d = ST_GUARD;
                        gcnt_d  = '0;
                    end else begin
                        dcnt_d = dcnt_q + DW'(1);
                    end
                end
                ST_GUARD: begin
                    if (gcnt_q == GUARD_LAST) begin
                        state_d = ST_DRIVE;
                        idx_d   = idx_q + 2'd1;
                        dcnt_d  = '0;
                    end else begin
                        gcnt_d = gcnt_q + GW'(1);
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    idx_d   = 2'd0;
                    dcnt_d  = '0;
                    gcnt_d  = '0;
                end
            endcase
        end
        tick_d = (state_d == ST_GUARD) && (gcnt_d == GUARD_LAST) && (idx_d == 2'd3);
    end

    // Shadow/display buffering; a coincident load lands in shadow after the commit
    always_comb begin
        commit_s = pending_q && (tick_q || (state_q == ST_OFF));
        ack_d    = commit_s;
        if (commit_s) begin
            disp_d = shadow_q;
        end else begin
            disp_d = disp_q;
        end
        if (bus.load) begin
            shadow_d  = bus.data;
            pending_d = 1'b1;
        end else begin
            shadow_d  = shadow_q;
            pending_d = pending_q && !commit_s;
        end
    end

    display_scan_ctrl_encoder u_encoder (
        .bcd_i     (cur_digit_s),
        .abcdefg_o (enc_seg_s)
    );

    // Output pattern for the upcoming cycle, built from next-state values so the
    // registered outputs line up with the state they belong to
    always_comb begin
        cur_digit_s = disp_d[{idx_d, 2'b00} +: 4];
        blank_s     = bus.lz_blank && (idx_d != 2'd0) &&
                      ((disp_d >> {idx_d, 2'b00}) == 16'h0000);
        an_d        = AN_OFF;
        seg_d       = SEG_BLANK;
        if ((state_d == ST_DRIVE) && !blank_s) begin
            an_d = an_select(idx_d);
            if (cur_digit_s <= BCD_MAX) begin
                seg_d = enc_seg_s;
            end else begin
                seg_d = SEG_BLANK;
            end
        end else begin
            an_d  = AN_OFF;
            seg_d = SEG_BLANK;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_OFF;
            idx_q     <= 2'd0;
            dcnt_q    <= '0;
            gcnt_q    <= '0;
            shadow_q  <= 16'h0000;
            disp_q    <= 16'h0000;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
            tick_q    <= 1'b0;
            an_q      <= AN_OFF;
            seg_q     <= SEG_BLANK;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            dcnt_q    <= dcnt_d;
            gcnt_q    <= gcnt_d;
            shadow_q  <= shadow_d;
            disp_q    <= disp_d;
            pending_q <= pending_d;
            ack_q     <= ack_d;
            tick_q    <= tick_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.abcdefg    = seg_q;
    assign bus.pending    = pending_q;
    assign bus.load_ack   = ack_q;
    assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench: a frame-position reference model queues the expected outputs
// each clock; an independent monitor pops and compares them on the falling edge.
module tb_display_scan_ctrl;

    localparam int DIV   = 4;
    localparam int GUARD = 1;
    localparam int SLOT  = DIV + GUARD;
    localparam int FL    = 4 * SLOT;

    localparam logic [6:0] SEG_TBL [10] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
    };

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       pend;
        logic       ack;
        logic       tick;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    display_scan_ctrl_if bus ();

    display_scan_ctrl #(.DIV(DIV), .GUARD(GUARD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Reference model: position m_t within a FL-cycle frame since scanning began
    bit          m_run, m_pend, m_ack, m_tick, m_commit, m_blank, m_drive;
    int          m_t, m_slot;
    logic [15:0] m_shadow, m_disp, m_upper;
    exp_t        m_e;

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            m_run = 0; m_t = 0; m_pend = 0; m_ack = 0; m_tick = 0;
            m_shadow = 16'h0000; m_disp = 16'h0000;
            m_e = '{an: 4'hF, seg: 7'h00, pend: 1'b0, ack: 1'b0, tick: 1'b0};
            exp_q.push_back(m_e);
        end else begin
            m_commit = m_pend && (m_tick || !m_run);
            if (m_commit) m_disp = m_shadow;
            m_ack = m_commit;
            if (bus.load) begin
                m_shadow = bus.data;
                m_pend   = 1;
            end else if (m_commit) begin
                m_pend = 0;
            end
            if (!bus.enable) begin
                m_run = 0; m_t = 0;
            end else if (!m_run) begin
                m_run = 1; m_t = 0;
            end else begin
                m_t = (m_t + 1) % FL;
            end
            m_tick  = m_run && (m_t == FL - 1);
            m_slot  = m_t / SLOT;
            m_drive = m_run && ((m_t % SLOT) < DIV);
            m_upper = m_disp >> (4 * m_slot);
            m_blank = bus.lz_blank && (m_slot != 0) && (m_upper == 16'h0000);
            m_e.an  = 4'hF;
            m_e.seg = 7'h00;
            if (m_drive && !m_blank) begin
                m_e.an = 4'hF & ~(4'(1) << m_slot);
                if (m_upper[3:0] < 4'd10) m_e.seg = SEG_TBL[m_upper[3:0]];
            end
            m_e.pend = m_pend;
            m_e.ack  = m_ack;
            m_e.tick = m_tick;
            exp_q.push_back(m_e);
        end
    end

    // An asynchronous reset invalidates whatever was predicted for this cycle
    initial forever begin
        @(negedge rst_n);
        exp_q.delete();
    end

    exp_t mon_e;
    initial forever begin
        @(negedge clk);
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("an",         {12'd0, bus.an},        {12'd0, mon_e.an});
            chk("abcdefg",    {9'd0, bus.abcdefg},    {9'd0, mon_e.seg});
            chk("pending",    {15'd0, bus.pending},   {15'd0, mon_e.pend});
            chk("load_ack",   {15'd0, bus.load_ack},  {15'd0, mon_e.ack});
            chk("frame_tick", {15'd0, bus.frame_tick}, {15'd0, mon_e.tick});
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ld(input logic [15:0] d);
        bus.load = 1'b1;
        bus.data = d;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic wait_an(input logic [3:0] pat);
        int k = 0;
        while (bus.an !== pat && k < 4 * FL) begin
            @(negedge clk);
            k++;
        end
        chk("wait_an", {15'd0, bus.an === pat}, 16'd1);
    endtask

    task automatic wait_tick();
        int k = 0;
        while (bus.frame_tick !== 1'b1 && k < 4 * FL) begin
            @(negedge clk);
            k++;
        end
        chk("wait_tick", {15'd0, bus.frame_tick === 1'b1}, 16'd1);
    endtask

    initial begin
        bus.enable   = 1'b0;
        bus.load     = 1'b0;
        bus.data     = 16'h0000;
        bus.lz_blank = 1'b0;
        cycles(3);
        rst_n = 1'b1;

        // Load while off commits at once, then scan starts
        ld(16'h1234);
        cycles(2);
        bus.enable = 1'b1;
        cycles(2 * FL);

        // Mid-frame load waits for the frame boundary
        cycles(7);
        ld(16'h5678);
        cycles(2 * FL);

        // Load coincident with frame_tick
        wait_tick();
        ld(16'h9ABC);
        cycles(3 * FL);

        // Leading-zero blanking and non-decimal code
        bus.lz_blank = 1'b1;
        ld(16'h0007);
        cycles(2 * FL);
        ld(16'h00A0);
        cycles(2 * FL);

        // Enable dropped while driving digit 2
        bus.lz_blank = 1'b0;
        ld(16'h1234);
        cycles(2 * FL);
        wait_an(4'b1011);
        cycles(1);
        bus.enable = 1'b0;
        cycles(10);
        bus.enable = 1'b1;
        cycles(2 * FL);

        // Randomised traffic
        for (int i = 0; i < 800; i++) begin
            bus.enable = ($urandom % 16) != 0;
            bus.load   = ($urandom % 8) == 0;
            bus.data   = 16'($urandom);
            if (($urandom % 64) == 0) bus.lz_blank = ~bus.lz_blank;
            @(negedge clk);
        end
        bus.load     = 1'b0;
        bus.enable   = 1'b1;
        bus.lz_blank = 1'b0;
        cycles(2 * FL);

        // Asynchronous reset mid-DRIVE with data pending
        ld(16'h1111);
        cycles(2 * FL);
        wait_an(4'b1110);
        ld(16'h4321);
        wait_an(4'b1101);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_an",      {12'd0, bus.an},         16'h000F);
        chk("rst_seg",     {9'd0, bus.abcdefg},     16'h0000);
        chk("rst_pending", {15'd0, bus.pending},    16'h0000);
        chk("rst_ack",     {15'd0, bus.load_ack},   16'h0000);
        chk("rst_tick",    {15'd0, bus.frame_tick}, 16'h0000);
        cycles(2);
        rst_n = 1'b1;
        cycles(2 * FL);

        cycles(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
